// File: rtl/rf80386_prefetch_queue.sv
// Instruction prefetch byte queue: multi-line circular byte buffer between fetch and decode.
// Fetches whole lines, trims the redirect offset from the first one, and presents a head-aligned window.
module rf80386_prefetch_queue #(
  parameter int LINE_BYTES  = 16,
  parameter int DEPTH_LINES = 2,
  parameter int OUT_BYTES   = 8,
  parameter int ADDR_W      = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic [ADDR_W-1:0]                           flush_addr_i,
  output logic                                        fetch_req_o,
  output logic [ADDR_W-1:0]                           fetch_addr_o,
  input  logic                                        fetch_ack_i,
  input  logic [LINE_BYTES*8-1:0]                     fetch_line_i,
  input  logic                                        consume_i,
  input  logic [$clog2(OUT_BYTES+1)-1:0]              consume_cnt_i,
  output logic [OUT_BYTES*8-1:0]                      win_o,
  output logic [$clog2(OUT_BYTES+1)-1:0]              win_cnt_o,
  output logic [ADDR_W-1:0]                           win_addr_o,
  output logic [$clog2(LINE_BYTES*DEPTH_LINES+1)-1:0] count_o,
  output logic                                        overrun_o
);

  localparam int CAP   = LINE_BYTES * DEPTH_LINES;
  localparam int PTR_W = $clog2(CAP);
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int WC_W  = $clog2(OUT_BYTES + 1);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int SW    = CNT_W + 1;

  localparam logic [SW-1:0] CAP_S   = SW'(CAP);
  localparam logic [SW-1:0] LINE_S  = SW'(LINE_BYTES);
  localparam logic [SW-1:0] REQ_MAX = SW'(CAP - LINE_BYTES);
  localparam logic [SW-1:0] OUT_S   = SW'(OUT_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  function automatic logic [PTR_W-1:0] wrap_ptr(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = (s >= CAP_S) ? s - CAP_S : s;
    return r[PTR_W-1:0];
  endfunction

  logic [1:0]                 state_q, state_d;
  logic                       started_q;
  logic [OFF_W-1:0]           skip_q;
  logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ADDR_W-1:0]          fetch_addr_q, win_addr_q;
  logic [OUT_BYTES-1:0][7:0]  win_q, win_d;
  logic [WC_W-1:0]            win_cnt_q, win_cnt_d;
  logic                       overrun_q;
  logic [7:0]                 buf_q [CAP];
  logic [7:0]                 buf_d [CAP];
  logic [LINE_BYTES-1:0][7:0] line_b;

  logic            wr_en, take, over;
  logic [SW-1:0]   wr_n, cnt_sum;
  logic [WC_W-1:0] eff;

  assign line_b = fetch_line_i;

  // Flush beats both an ack and a consume in the same cycle.
  assign wr_en   = fetch_ack_i && (state_q == S_REQ) && !flush_i;
  assign wr_n    = wr_en ? LINE_S - SW'(skip_q) : '0;
  assign take    = consume_i && !flush_i;
  assign over    = take && (consume_cnt_i > win_cnt_q);
  assign eff     = !take ? '0 : (over ? win_cnt_q : consume_cnt_i);
  assign cnt_sum = SW'(count_q) + wr_n - SW'(eff);

  assign count_d   = flush_i ? '0 : cnt_sum[CNT_W-1:0];
  assign head_d    = flush_i ? '0 : wrap_ptr(SW'(head_q) + SW'(eff));
  assign tail_d    = flush_i ? '0 : wrap_ptr(SW'(tail_q) + wr_n);
  assign win_cnt_d = (SW'(count_d) > OUT_S) ? WC_W'(OUT_BYTES) : count_d[WC_W-1:0];

  // Each slot checks whether it lies in the freshly written run starting at tail.
  always_comb begin
    for (int i = 0; i < CAP; i++) begin
      logic [PTR_W-1:0] rel;
      logic [SW-1:0]    src;
      rel = wrap_ptr(SW'(i) + CAP_S - SW'(tail_q));
      src = SW'(rel) + SW'(skip_q);
      buf_d[i] = buf_q[i];
      if (wr_en && (SW'(rel) < wr_n)) buf_d[i] = line_b[src[OFF_W-1:0]];
    end
  end

  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_win
    assign win_d[gi] = (SW'(gi) < SW'(win_cnt_d)) ? buf_d[wrap_ptr(SW'(head_d) + SW'(gi))] : 8'h90;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (started_q && (SW'(count_q) <= REQ_MAX)) state_d = S_REQ;
      S_REQ:   if (fetch_ack_i) state_d = S_IDLE;
      // DROP is only entered on a redirect, so a refetch is always owed afterwards.
      S_DROP:  if (fetch_ack_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = ((state_q != S_IDLE) && !fetch_ack_i) ? S_DROP : S_REQ;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      started_q    <= 1'b0;
      skip_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fetch_addr_q <= '0;
      win_addr_q   <= '0;
      win_q        <= {OUT_BYTES{8'h90}};
      win_cnt_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      overrun_q <= over;
      if (flush_i) begin
        started_q    <= 1'b1;
        skip_q       <= flush_addr_i[OFF_W-1:0];
        fetch_addr_q <= {flush_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        win_addr_q   <= flush_addr_i;
      end else begin
        win_addr_q <= win_addr_q + ADDR_W'(eff);
        if (wr_en) begin
          skip_q       <= '0;
          fetch_addr_q <= fetch_addr_q + ADDR_W'(LINE_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q <= buf_d;
  end

  assign fetch_req_o  = (state_q != S_IDLE);
  assign fetch_addr_o = fetch_addr_q;
  assign win_o        = win_q;
  assign win_cnt_o    = win_cnt_q;
  assign win_addr_o   = win_addr_q;
  assign count_o      = count_q;
  assign overrun_o    = overrun_q;

endmodule
